// File: rtl/fsb_region_decoder.sv
// Front-side-bus slave decoder: N address regions, read-data mux, wait-state/ready
// completion, bus timeout watchdog and sticky fault capture.
module fsb_region_decoder #(
    parameter int unsigned            REGIONS   = 4,
    parameter int unsigned            AW        = 32,
    parameter int unsigned            DW        = 32,
    parameter logic [REGIONS*AW-1:0]  BASES     = {32'h3000, 32'h2000, 32'h1000, 32'h0},
    parameter logic [REGIONS*AW-1:0]  LIMITS    = {32'h800000, 32'h3000, 32'h2000, 32'h1000},
    parameter logic [REGIONS*4-1:0]   WAITS     = 16'h0000,
    parameter logic [REGIONS-1:0]     USE_READY = 4'b1000,
    parameter int unsigned            TIMEOUT   = 255,
    parameter int unsigned            TIMEOUT_W = 8,
    parameter logic [DW-1:0]          FILL      = 32'h0
) (
    input  logic                  iBusClock,
    input  logic                  iBusReset,
    input  logic [AW-1:0]         iAddress,
    input  logic                  iWrite,
    input  logic                  iAccess,
    output logic                  oReady,
    output logic [DW-1:0]         oReadData,
    output logic [REGIONS-1:0]    oSelect,
    output logic [REGIONS-1:0]    oWriteEnable,
    input  logic [REGIONS*DW-1:0] iRegionData,
    input  logic [REGIONS-1:0]    iRegionReady,
    input  logic                  iFaultClear,
    output logic                  oFault,
    output logic [AW-1:0]         oFaultAddress,
    output logic                  oFaultWrite,
    output logic                  oFaultTimeout
);

    localparam int unsigned RW = (REGIONS > 1) ? $clog2(REGIONS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE, ST_RELEASE} state_t;

    state_t                 state_q, state_d;
    logic [RW-1:0]          region_q, region_d;
    logic                   write_q, write_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [3:0]             wait_q, wait_d;
    logic [TIMEOUT_W-1:0]   timer_q, timer_d;
    logic                   fault_path_q, fault_path_d;
    logic                   ready_q, ready_d;
    logic [REGIONS-1:0]     we_q, we_d;
    logic [DW-1:0]          rdata_q, rdata_d;
    logic                   fault_q, fault_d;
    logic [AW-1:0]          fault_addr_q, fault_addr_d;
    logic                   fault_write_q, fault_write_d;
    logic                   fault_to_q, fault_to_d;

    logic                   hit_c;
    logic [RW-1:0]          idx_c;
    logic [REGIONS-1:0]     sel_c;
    logic                   complete_c;
    logic                   capture_c;
    logic                   capture_to_c;
    logic [AW-1:0]          capture_addr_c;
    logic                   capture_write_c;

    // Region hit: (addr - base) < (limit - base) is base <= addr < limit for base <= limit
    always_comb begin
        hit_c = 1'b0;
        idx_c = '0;
        sel_c = '0;
        for (int i = 0; i < REGIONS; i++) begin
            if (!hit_c && ((iAddress - BASES[i*AW +: AW]) <
                           (LIMITS[i*AW +: AW] - BASES[i*AW +: AW]))) begin
                hit_c = 1'b1;
                idx_c = RW'(i);
            end
        end
        if (hit_c) begin
            sel_c = REGIONS'(1) << idx_c;
        end
    end

    assign oSelect    = sel_c;
    assign complete_c = (wait_q == 4'd0) && (!USE_READY[region_q] || iRegionReady[region_q]);

    always_comb begin
        state_d         = state_q;
        region_d        = region_q;
        write_d         = write_q;
        addr_d          = addr_q;
        wait_d          = wait_q;
        timer_d         = timer_q;
        fault_path_d    = fault_path_q;
        rdata_d         = rdata_q;
        fault_d         = fault_q;
        fault_addr_d    = fault_addr_q;
        fault_write_d   = fault_write_q;
        fault_to_d      = fault_to_q;
        ready_d         = 1'b0;
        we_d            = '0;
        capture_c       = 1'b0;
        capture_to_c    = 1'b0;
        capture_addr_c  = addr_q;
        capture_write_c = write_q;

        if (iFaultClear) begin
            fault_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (iAccess) begin
                    addr_d  = iAddress;
                    write_d = iWrite;
                    if (hit_c) begin
                        region_d     = idx_c;
                        wait_d       = WAITS[idx_c*4 +: 4];
                        timer_d      = '0;
                        fault_path_d = 1'b0;
                        state_d      = ST_WAIT;
                    end else begin
                        fault_path_d    = 1'b1;
                        rdata_d         = FILL;
                        capture_c       = 1'b1;
                        capture_addr_c  = iAddress;
                        capture_write_c = iWrite;
                        state_d         = ST_DONE;
                    end
                end
            end
            ST_WAIT: begin
                // Completion is tested first so it wins over a coincident timeout
                if (complete_c) begin
                    rdata_d = iRegionData[region_q*DW +: DW];
                    state_d = ST_DONE;
                end else if (timer_q == TIMEOUT_W'(TIMEOUT)) begin
                    fault_path_d = 1'b1;
                    rdata_d      = FILL;
                    capture_c    = 1'b1;
                    capture_to_c = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    if (wait_q != 4'd0) begin
                        wait_d = wait_q - 4'd1;
                    end
                    timer_d = timer_q + TIMEOUT_W'(1);
                end
            end
            ST_DONE: begin
                ready_d = 1'b1;
                if (write_q && !fault_path_q) begin
                    we_d = REGIONS'(1) << region_q;
                end
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!iAccess) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // First fault since clear is kept; a clear on the same edge lets the new one in
        if (capture_c && (!fault_q || iFaultClear)) begin
            fault_d       = 1'b1;
            fault_addr_d  = capture_addr_c;
            fault_write_d = capture_write_c;
            fault_to_d    = capture_to_c;
        end
    end

    always_ff @(posedge iBusClock) begin
        if (!iBusReset) begin
            state_q       <= ST_IDLE;
            region_q      <= '0;
            write_q       <= 1'b0;
            addr_q        <= '0;
            wait_q        <= '0;
            timer_q       <= '0;
            fault_path_q  <= 1'b0;
            ready_q       <= 1'b0;
            we_q          <= '0;
            rdata_q       <= '0;
            fault_q       <= 1'b0;
            fault_addr_q  <= '0;
            fault_write_q <= 1'b0;
            fault_to_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            region_q      <= region_d;
            write_q       <= write_d;
            addr_q        <= addr_d;
            wait_q        <= wait_d;
            timer_q       <= timer_d;
            fault_path_q  <= fault_path_d;
            ready_q       <= ready_d;
            we_q          <= we_d;
            rdata_q       <= rdata_d;
            fault_q       <= fault_d;
            fault_addr_q  <= fault_addr_d;
            fault_write_q <= fault_write_d;
            fault_to_q    <= fault_to_d;
        end
    end

    assign oReady        = ready_q;
    assign oWriteEnable  = we_q;
    assign oReadData     = rdata_q;
    assign oFault        = fault_q;
    assign oFaultAddress = fault_addr_q;
    assign oFaultWrite   = fault_write_q;
    assign oFaultTimeout = fault_to_q;

endmodule

// File: tb/tb_fsb_region_decoder.sv
// Bench for fsb_region_decoder: directed scenarios plus randomized accesses
// checked against a latency/fault model derived from the region map.
module tb_fsb_region_decoder;

    localparam int unsigned TO    = 255;
    localparam logic [31:0] FILLV = 32'hBAD0_F111;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  iAddress;
    logic         iWrite, iAccess, iFaultClear;
    logic         oReady, oFault, oFaultWrite, oFaultTimeout;
    logic [31:0]  oReadData, oFaultAddress;
    logic [3:0]   oSelect, oWriteEnable, iRegionReady;
    logic [127:0] iRegionData;
    logic         rdy3;
    logic [31:0]  m_data [4];

    always #5 clk = ~clk;

    assign iRegionReady = {rdy3, 3'b000};
    assign iRegionData  = {m_data[3], m_data[2], m_data[1], m_data[0]};

    fsb_region_decoder #(
        .REGIONS(4), .AW(32), .DW(32),
        .BASES({32'h3000, 32'h2000, 32'h1000, 32'h0}),
        .LIMITS({32'h800000, 32'h3000, 32'h2000, 32'h1000}),
        .WAITS(16'h0530), .USE_READY(4'b1000),
        .TIMEOUT(TO), .TIMEOUT_W(8), .FILL(FILLV)
    ) dut (
        .iBusClock(clk), .iBusReset(rst_n), .iAddress(iAddress), .iWrite(iWrite),
        .iAccess(iAccess), .oReady(oReady), .oReadData(oReadData), .oSelect(oSelect),
        .oWriteEnable(oWriteEnable), .iRegionData(iRegionData), .iRegionReady(iRegionReady),
        .iFaultClear(iFaultClear), .oFault(oFault), .oFaultAddress(oFaultAddress),
        .oFaultWrite(oFaultWrite), .oFaultTimeout(oFaultTimeout)
    );

    // Reference region map
    logic [31:0] m_base  [4] = '{32'h0, 32'h1000, 32'h2000, 32'h3000};
    logic [31:0] m_limit [4] = '{32'h1000, 32'h2000, 32'h3000, 32'h800000};
    int          m_wait  [4] = '{0, 3, 5, 0};
    bit          m_rdy   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    logic        m_fault, m_fwrite, m_fto;
    logic [31:0] m_faddr;
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic int region_of(input logic [31:0] a);
        for (int i = 0; i < 4; i++)
            if (a >= m_base[i] && a < m_limit[i]) return i;
        return -1;
    endfunction

    // Expected response; d = cycles after the sample edge before ready[3] rises (-1: never)
    task automatic model_access(input logic [31:0] a, input logic wr, input int d,
                                output logic [3:0] sel, output int lat,
                                output logic [31:0] rd, output logic [3:0] we);
        int  r, done;
        logic flt, to;
        r = region_of(a); flt = 1'b0; to = 1'b0; done = 0;
        if (r < 0) flt = 1'b1;
        else begin
            done = 1 + m_wait[r];
            if (m_rdy[r]) done = (d < 0) ? 1_000_000 : ((d + 1 > done) ? d + 1 : done);
            if (done > TO + 1) begin done = TO + 1; flt = 1'b1; to = 1'b1; end
        end
        sel = (r < 0) ? 4'b0 : 4'(1 << r);
        lat = done + 1;
        rd  = flt ? FILLV : m_data[r];
        we  = (!flt && wr) ? 4'(1 << r) : 4'b0;
        if (flt && !m_fault) begin m_fault = 1'b1; m_faddr = a; m_fwrite = wr; m_fto = to; end
    endtask

    // Drives one access; lat = cycles from sample edge to first observed oReady (-1: none)
    task automatic run_access(input logic [31:0] a, input logic wr, input int d, input int hold,
                              output logic [3:0] sel, output int lat,
                              output logic [31:0] rd, output logic [3:0] we, output int stray);
        lat = -1; rd = '0; we = '0; stray = 0;
        iAddress = a; iWrite = wr; iAccess = 1'b1; rdy3 = (d == 0);
        @(posedge clk); #1;
        sel = oSelect;
        iAddress = $urandom; iWrite = 1'($urandom);
        for (int k = 1; k <= int'(TO) + 20 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (k == d) rdy3 = 1'b1;
            if (oReady) begin lat = k; rd = oReadData; we = oWriteEnable; end
            else if (oWriteEnable != 4'b0) stray++;
        end
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            if (oReady || oWriteEnable != 4'b0) stray++;
        end
        iAccess = 1'b0; rdy3 = 1'b0;
        @(posedge clk); #1;
        if (oReady || oWriteEnable != 4'b0) stray++;
        @(posedge clk); #1;
    endtask

    task automatic pulse_clear();
        iFaultClear = 1'b1;
        @(posedge clk); #1;
        iFaultClear = 1'b0;
        m_fault = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; iAccess = 1'b0; iWrite = 1'b0; iAddress = '0; iFaultClear = 1'b0; rdy3 = 1'b0;
        for (int i = 0; i < 4; i++) m_data[i] = $urandom;
        m_fault = 1'b0; m_faddr = '0; m_fwrite = 1'b0; m_fto = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({oReady, oWriteEnable} !== 5'b0) begin n_err++; $display("FAIL reset_strobes: got %b want 0", {oReady, oWriteEnable}); end
        n_cmp++; if (oReadData !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", oReadData); end
        n_cmp++; if ({oFault, oFaultWrite, oFaultTimeout, oFaultAddress} !== 35'b0) begin n_err++; $display("FAIL reset_fault: got %b %b %b %h want all 0", oFault, oFaultWrite, oFaultTimeout, oFaultAddress); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_region0();
        logic [3:0] sel, esel, we, ewe; int lat, elat, stray; logic [31:0] rd, erd;
        m_data[0] = 32'hDEADBEEF;
        model_access(32'h0500, 1'b0, 0, esel, elat, erd, ewe);
        run_access(32'h0500, 1'b0, 0, 0, sel, lat, rd, we, stray);
        n_cmp++; if (sel !== esel) begin n_err++; $display("FAIL rd0_select: got %b want %b", sel, esel); end
        n_cmp++; if (lat !== elat) begin n_err++; $display("FAIL rd0_latency: got %0d want %0d", lat, elat); end
        n_cmp++; if (rd !== erd) begin n_err++; $display("FAIL rd0_data: got %h want %h", rd, erd); end
        n_cmp++; if (oFault !== 1'b0) begin n_err++; $display("FAIL rd0_fault: got %b want 0", oFault); end
    endtask

    task automatic test_write_wait();
        logic [3:0] sel, esel, we, ewe; int lat, elat, stray; logic [31:0] rd, erd;
        model_access(32'h1004, 1'b1, 0, esel, elat, erd, ewe);
        run_access(32'h1004, 1'b1, 0, 0, sel, lat, rd, we, stray);
        n_cmp++; if (lat !== elat) begin n_err++; $display("FAIL wr1_latency: got %0d want %0d", lat, elat); end
        n_cmp++; if (we !== ewe) begin n_err++; $display("FAIL wr1_strobe: got %b want %b", we, ewe); end
        n_cmp++; if (stray !== 0) begin n_err++; $display("FAIL wr1_stray: got %0d extra pulses want 0", stray); end
    endtask

    task automatic test_ready();
        logic [3:0] sel, esel, we, ewe; int lat, elat, stray; logic [31:0] rd, erd;
        m_data[3] = 32'h3A3A_0003;
        model_access(32'h3000, 1'b0, 10, esel, elat, erd, ewe);
        run_access(32'h3000, 1'b0, 10, 0, sel, lat, rd, we, stray);
        n_cmp++; if (lat !== elat) begin n_err++; $display("FAIL rdy3_latency: got %0d want %0d", lat, elat); end
        n_cmp++; if (rd !== erd) begin n_err++; $display("FAIL rdy3_data: got %h want %h", rd, erd); end
        n_cmp++; if (oFault !== 1'b0) begin n_err++; $display("FAIL rdy3_fault: got %b want 0", oFault); end
    endtask

    task automatic test_unmapped();
        logic [3:0] sel, esel, we, ewe; int lat, elat, stray; logic [31:0] rd, erd;
        model_access(32'h900000, 1'b0, 0, esel, elat, erd, ewe);
        run_access(32'h900000, 1'b0, 0, 0, sel, lat, rd, we, stray);
        n_cmp++; if (sel !== 4'b0) begin n_err++; $display("FAIL unm_select: got %b want 0000", sel); end
        n_cmp++; if (lat !== elat) begin n_err++; $display("FAIL unm_latency: got %0d want %0d", lat, elat); end
        n_cmp++; if (rd !== erd) begin n_err++; $display("FAIL unm_data: got %h want %h", rd, erd); end
        n_cmp++; if ({oFault, oFaultTimeout, oFaultAddress} !== {1'b1, 1'b0, 32'h900000}) begin n_err++; $display("FAIL unm_capture: got %b %b %h want 1 0 00900000", oFault, oFaultTimeout, oFaultAddress); end
        model_access(32'hA00000, 1'b1, 0, esel, elat, erd, ewe);
        run_access(32'hA00000, 1'b1, 0, 0, sel, lat, rd, we, stray);
        n_cmp++; if (we !== 4'b0) begin n_err++; $display("FAIL unm_wr_strobe: got %b want 0000", we); end
        n_cmp++; if ({oFaultAddress, oFaultWrite} !== {m_faddr, m_fwrite}) begin n_err++; $display("FAIL unm_sticky: got %h %b want %h %b", oFaultAddress, oFaultWrite, m_faddr, m_fwrite); end
    endtask

    task automatic test_timeout();
        logic [3:0] sel, esel, we, ewe; int lat, elat, stray; logic [31:0] rd, erd;
        pulse_clear();
        n_cmp++; if (oFault !== 1'b0) begin n_err++; $display("FAIL to_preclear: got %b want 0", oFault); end
        model_access(32'h3010, 1'b0, -1, esel, elat, erd, ewe);
        run_access(32'h3010, 1'b0, -1, 0, sel, lat, rd, we, stray);
        n_cmp++; if (lat !== elat) begin n_err++; $display("FAIL to_latency: got %0d want %0d", lat, elat); end
        n_cmp++; if (rd !== erd) begin n_err++; $display("FAIL to_data: got %h want %h", rd, erd); end
        n_cmp++; if ({oFault, oFaultTimeout, oFaultAddress} !== {1'b1, 1'b1, 32'h3010}) begin n_err++; $display("FAIL to_capture: got %b %b %h want 1 1 00003010", oFault, oFaultTimeout, oFaultAddress); end
        pulse_clear();
        n_cmp++; if (oFault !== 1'b0) begin n_err++; $display("FAIL to_clear: got %b want 0", oFault); end
        // Ready arriving on the timeout edge completes normally
        model_access(32'h3020, 1'b0, int'(TO), esel, elat, erd, ewe);
        run_access(32'h3020, 1'b0, int'(TO), 0, sel, lat, rd, we, stray);
        n_cmp++; if ({lat, rd, oFault} !== {elat, erd, 1'b0}) begin n_err++; $display("FAIL to_tie: got lat %0d data %h fault %b want %0d %h 0", lat, rd, oFault, elat, erd); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] sel, esel, we, ewe; int lat, elat, stray, seen; logic [31:0] rd, erd;
        model_access(32'hF000_0000, 1'b1, 0, esel, elat, erd, ewe);
        run_access(32'hF000_0000, 1'b1, 0, 0, sel, lat, rd, we, stray);
        iAddress = 32'h2008; iWrite = 1'b1; iAccess = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if ({oReady, oWriteEnable, oReadData} !== 37'b0) begin n_err++; $display("FAIL rstmid_outputs: got %b %b %h want 0", oReady, oWriteEnable, oReadData); end
        n_cmp++; if ({oFault, oFaultTimeout, oFaultWrite, oFaultAddress} !== 35'b0) begin n_err++; $display("FAIL rstmid_fault: got %b %b %b %h want 0", oFault, oFaultTimeout, oFaultWrite, oFaultAddress); end
        m_fault = 1'b0;
        iAccess = 1'b0; rst_n = 1'b1; seen = 0;
        repeat (8) begin @(posedge clk); #1; if (oReady || oWriteEnable != 4'b0) seen++; end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rstmid_noready: got %0d pulses want 0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] sel, esel, we, ewe; int lat, elat, stray; logic [31:0] rd, erd;
        model_access(32'h0ABC, 1'b0, 0, esel, elat, erd, ewe);
        run_access(32'h0ABC, 1'b0, 0, 5, sel, lat, rd, we, stray);
        n_cmp++; if ({lat, stray} !== {elat, 32'd0}) begin n_err++; $display("FAIL hold_single: got lat %0d extra %0d want %0d 0", lat, stray, elat); end
        model_access(32'h2FFF, 1'b1, 0, esel, elat, erd, ewe);
        run_access(32'h2FFF, 1'b1, 0, 0, sel, lat, rd, we, stray);
        n_cmp++; if ({lat, we} !== {elat, ewe}) begin n_err++; $display("FAIL b2b_second: got lat %0d we %b want %0d %b", lat, we, elat, ewe); end
    endtask

    task automatic test_random();
        logic [3:0] sel, esel, we, ewe; int lat, elat, stray, pick, r, d; logic [31:0] rd, erd, a; logic wr;
        for (int n = 0; n < 20; n++) begin
            iAddress = $urandom; #1;
            r = region_of(iAddress);
            n_cmp++; if (oSelect !== ((r < 0) ? 4'b0 : 4'(1 << r))) begin n_err++; $display("FAIL rnd_decode: addr %h got %b", iAddress, oSelect); end
        end
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 4; i++) m_data[i] = $urandom;
            pick = $urandom_range(0, 5);
            if (pick < 4) a = m_base[pick] + ($urandom % (m_limit[pick] - m_base[pick]));
            else if (pick == 4) a = $urandom | 32'h0080_0000;
            else begin r = $urandom_range(0, 3); a = m_limit[r] - 32'($urandom_range(0, 1)); end
            wr = 1'($urandom); d = $urandom_range(0, 12);
            if ($urandom_range(0, 3) == 0) pulse_clear();
            model_access(a, wr, d, esel, elat, erd, ewe);
            run_access(a, wr, d, $urandom_range(0, 2), sel, lat, rd, we, stray);
            n_cmp++; if (sel !== esel) begin n_err++; $display("FAIL rnd_select: addr %h got %b want %b", a, sel, esel); end
            n_cmp++; if (lat !== elat) begin n_err++; $display("FAIL rnd_latency: addr %h got %0d want %0d", a, lat, elat); end
            n_cmp++; if (rd !== erd) begin n_err++; $display("FAIL rnd_data: addr %h got %h want %h", a, rd, erd); end
            n_cmp++; if ({we, stray} !== {ewe, 32'd0}) begin n_err++; $display("FAIL rnd_strobe: addr %h got %b extra %0d want %b 0", a, we, stray, ewe); end
            n_cmp++; if (oFault !== m_fault) begin n_err++; $display("FAIL rnd_fault: addr %h got %b want %b", a, oFault, m_fault); end
            if (m_fault) begin
                n_cmp++; if ({oFaultAddress, oFaultWrite, oFaultTimeout} !== {m_faddr, m_fwrite, m_fto}) begin n_err++; $display("FAIL rnd_capture: got %h %b %b want %h %b %b", oFaultAddress, oFaultWrite, oFaultTimeout, m_faddr, m_fwrite, m_fto); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_region0();
        test_write_wait();
        test_ready();
        test_unmapped();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
